// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the two-requester UART TX arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam logic [7:0] ARB_DEFAULT_EOL = 8'h0A;
  localparam int         ARB_TMO_W       = 16;

endpackage

// File: rtl/uart_tx_arbiter.sv
// Line-locking 2:1 arbiter in front of the uart TX FIFO; UART_ARB_TIMEOUT_EN adds an idle-lock timeout.
// Grant one cycle after request, then zero-latency pass-through; TX FIFO wready flows straight back to the owner only.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned               data_width = 8,
  parameter logic [data_width-1:0]     eol_char   = ARB_DEFAULT_EOL,
  parameter int unsigned               timeout    = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] wdata0,
  input  logic                  wvalid0,
  output logic                  wready0,
  input  logic [data_width-1:0] wdata1,
  input  logic                  wvalid1,
  output logic                  wready1,
  output logic [data_width-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  output logic                  owner,
  output logic                  busy
);

  if (timeout < 1 || timeout > 65535) begin : g_timeout_range
    $error("uart_tx_arbiter: timeout must be within 1..65535");
  end

  arb_state_t            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [data_width-1:0] sel_dat;
  logic                  sel_vld;
  logic                  hs;
  logic                  eol_hs;
  logic                  tmo_hit;

  assign sel_dat = owner_q ? wdata1 : wdata0;
  assign sel_vld = owner_q ? wvalid1 : wvalid0;
  assign hs      = (state_q == ARB_LOCKED) && sel_vld && wready;
  assign eol_hs  = hs && (sel_dat == eol_char);

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [ARB_TMO_W-1:0] TMO_LAST = ARB_TMO_W'(timeout - 1);

  logic [ARB_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts consecutive LOCKED cycles without a handshake; IDLE holds it at zero.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit   = 1'b0;
    if (state_q == ARB_LOCKED && !hs) begin
      tmo_hit   = (tmo_cnt_q == TMO_LAST);
      tmo_cnt_d = tmo_hit ? '0 : tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wdata        = '0;
    wvalid       = 1'b0;
    wready0      = 1'b0;
    wready1      = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (wvalid0 || wvalid1) begin
        state_d = ARB_LOCKED;
        // On a tie the requester not served last wins.
        owner_d = (wvalid0 && wvalid1) ? ~last_owner_q : wvalid1;
      end
    end else begin
      wdata   = sel_dat;
      wvalid  = sel_vld;
      wready0 = ~owner_q & wready;
      wready1 =  owner_q & wready;
      if (eol_hs || tmo_hit) begin
        state_d      = ARB_IDLE;
        last_owner_d = owner_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign busy  = (state_q == ARB_LOCKED);
  assign owner = busy & owner_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter data_width, default 8: width of every data port.
REQ-002 Parameter eol_char, default 8'h0A: byte that ends a locked transfer.
REQ-003 Parameter timeout, default 65535: idle cycles before forced release; valid range 1..65535.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wdata0  input  data_width  requester 0 (ucmd FSM) TX byte.
REQ-007 wvalid0  input  1  requester 0 byte valid.
REQ-008 wready0  output  1  requester 0 byte accepted.
REQ-009 wdata1  input  data_width  requester 1 (echo path) TX byte.
REQ-010 wvalid1  input  1  requester 1 byte valid.
REQ-011 wready1  output  1  requester 1 byte accepted.
REQ-012 wdata  output  data_width  byte to uart TX FIFO.
REQ-013 wvalid  output  1  byte valid to uart TX FIFO.
REQ-014 wready  input  1  uart TX FIFO can accept.
REQ-015 owner  output  1  index of granted requester; 0 when not busy.
REQ-016 busy  output  1  high while a grant is held.

Function
REQ-017 Two states: IDLE, LOCKED; registered owner and last_owner.
REQ-018 IDLE: wvalid=0, wready0=0, wready1=0; wdata=0.
REQ-019 IDLE with exactly one wvalidN high: LOCKED, owner=N next cycle.
REQ-020 IDLE with both high: grant the requester not equal to last_owner.
REQ-021 Grant latency exactly one cycle from wvalidN seen in IDLE; no byte transfers in that cycle.
REQ-022 LOCKED: wdata/wvalid follow owner's inputs combinationally; owner's wready=wready; other wready=0.
REQ-023 Handshake = wvalid && wready; one byte per handshake, no buffering, no reordering.
REQ-024 Handshake of byte equal to eol_char: next cycle IDLE, last_owner=owner.
REQ-025 Non-owner requester holds wdata/wvalid stable until granted; the arbiter never drops or duplicates a byte.
REQ-026 busy = (state==LOCKED); owner output = registered owner gated by busy.
REQ-027 In IDLE both requesters asserting in the cycle an EOL release completes: the requester not just served wins (round-robin).

Reset
REQ-028 rst high: state=IDLE, owner=0, last_owner=1 (requester 0 wins first tie), timeout counter=0; all outputs 0 immediately.
REQ-029 Reset mid-transfer: grant dropped; the in-flight byte is not transferred after reset.

Configuration
REQ-030 UART_ARB_TIMEOUT_EN defined: 16-bit counter increments each LOCKED cycle without handshake, clears on handshake or entry to LOCKED; reaching timeout forces IDLE next cycle with last_owner=owner.
REQ-031 UART_ARB_TIMEOUT_EN undefined: no counter; lock released only by eol_char handshake or reset.

Structure
REQ-032 Shared package holds state encoding constants (ARB_IDLE, ARB_LOCKED) and the default EOL constant; no sub-module, single flat module.

Verification
REQ-033 Reset, then wvalid0 and wvalid1 high same cycle -> owner=0 one cycle later; "HI\n" from 0 passes in order; then owner=1 granted.
REQ-034 Requester 1 sends "AB" no EOL while requester 0 waits -> wready0 stays 0 the whole time; with UART_ARB_TIMEOUT_EN and timeout=16, release after 16 idle cycles, owner becomes 0.
REQ-035 wready held low 10 cycles mid-line -> wvalid stays high, wdata stable, no byte lost, no timeout release (timeout=16).
REQ-036 rst asserted while LOCKED on requester 1 -> busy=0, wready1=0 same cycle; after release tie goes to requester 0.
REQ-037 Alternating single-byte 8'h0A from both requesters, both always valid -> grants alternate 0,1,0,1, one byte per grant.
